// File: rtl/systolic_feed_ctrl_pkg.sv
// Purpose: shared state encodings, FP32 zero and drain-length helper for the systolic feed controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_feed_ctrl_pkg;

    // Sequencer states, in the order a job walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // +0.0 in IEEE-754 single; idle lanes carry this so 0*x contributes nothing.
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // Cycles after the last read until every accumulator is final:
    // 2N covers the worst-case skew plus array traversal, pe_lat the PE pipeline.
    function automatic int drain_len(input int n, input int pe_lat);
        return 2 * n + pe_lat;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Purpose: bundles start/status, operand-buffer read ports and array edge buses.
// Latency: n/a (wiring only).
// Backpressure: none; buffers answer every read one cycle later.
interface systolic_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 2
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   pe_clr;
    logic                   a_rd_en;
    logic [AW-1:0]          a_rd_addr;
    logic [N-1:0][DW-1:0]   a_rd_data;
    logic                   b_rd_en;
    logic [AW-1:0]          b_rd_addr;
    logic [N-1:0][DW-1:0]   b_rd_data;
    logic [N-1:0][DW-1:0]   left_data;
    logic [N-1:0][DW-1:0]   top_data;

    // Controller side.
    modport master (
        input  start, a_rd_data, b_rd_data,
        output busy, done, pe_clr,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output left_data, top_data
    );

    // Host, buffers and array side.
    modport slave (
        output start, a_rd_data, b_rd_data,
        input  busy, done, pe_clr,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  left_data, top_data
    );
endinterface

// File: rtl/systolic_feed_ctrl_skew.sv
// Purpose: DEPTH-stage data+valid delay line; output forced to +0.0 whenever its valid bit is low.
// Latency: DEPTH cycles from dat_i/vld_i to dat_o.
// Backpressure: none; shifts every cycle, clr_i zeroes every stage synchronously.
module skew_delay_line
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          vld_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o
);

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;

    // Shift register; invalid samples enter as zero so no stale word can travel down the chain.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= vld_i ? dat_i : DW'(FP32_ZERO);
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    // Final gate on the valid bit: outside its window the lane is exactly +0.0.
    assign dat_o = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : DW'(FP32_ZERO);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Purpose: sequences one NxN output-stationary matmul: clear PEs, read A columns/B rows, skew onto array edges, pulse done.
// Latency: done 3N+2+PE_LAT cycles after the start-sampling cycle; lane i/j data appears 4+k+i / 4+k+j cycles after it.
// Backpressure: none; start is ignored while busy and for one cycle after done (no queuing).
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 32,
    parameter int AW     = 2,
    parameter int PE_LAT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    systolic_feed_ctrl_if.master bus
);

    localparam int DL = drain_len(N, PE_LAT);
    localparam int CW = $clog2(DL);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               hold_q;
    logic               busy_q;
    logic               done_q;
    logic               pe_clr_q;
    logic               rd_en_q;
    logic [AW-1:0]      addr_q;
    logic               rd_vld_q;
    logic [N-1:0][DW-1:0] left_lane;
    logic [N-1:0][DW-1:0] top_lane;

    // Job sequencer with registered outputs. hold_q blocks start in the first
    // IDLE cycle after done, which sets the minimum issue interval.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hold_q <= 1'b0;
                    if (bus.start && !hold_q) begin
                        state_q  <= ST_CLEAR;
                        busy_q   <= 1'b1;
                        pe_clr_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    pe_clr_q <= 1'b0;
                    rd_en_q  <= 1'b1;
                    addr_q   <= '0;
                    cnt_q    <= '0;
                    state_q  <= ST_FEED;
                end
                ST_FEED: begin
                    // Address saturates at N-1 so a late strobe can never wrap to row 0.
                    if (addr_q != AW'(N-1)) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (cnt_q == CW'(N-1)) begin
                        rd_en_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CW'(DL-1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    cnt_q   <= '0;
                    hold_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffers answer one cycle after the strobe; this marks the cycle their data is real.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_en_q;
        end
    end

    // Lane g is delayed g+1 cycles so row/column g enters the array g cycles late.
    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_delay_line #(
            .DEPTH (g + 1),
            .DW    (DW)
        ) u_left (
            .clk_i (clk_i),
            .clr_i (rst_i),
            .vld_i (rd_vld_q),
            .dat_i (bus.a_rd_data[g]),
            .dat_o (left_lane[g])
        );

        skew_delay_line #(
            .DEPTH (g + 1),
            .DW    (DW)
        ) u_top (
            .clk_i (clk_i),
            .clr_i (rst_i),
            .vld_i (rd_vld_q),
            .dat_i (bus.b_rd_data[g]),
            .dat_o (top_lane[g])
        );
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pe_clr    = pe_clr_q;
    assign bus.a_rd_en   = rd_en_q;
    assign bus.a_rd_addr = addr_q;
    assign bus.b_rd_en   = rd_en_q;
    assign bus.b_rd_addr = addr_q;
    assign bus.left_data = left_lane;
    assign bus.top_data  = top_lane;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Purpose: self-checking bench for systolic_feed_ctrl with operand-buffer models and a job scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_feed_ctrl;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int AW      = 2;
    localparam int PE_LAT  = 3;
    localparam int DONE_T  = 3 * N + 2 + PE_LAT;
    localparam int JOB_INT = 3 * N + 4 + PE_LAT;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.N(N), .DW(DW), .AW(AW)) bus();

    systolic_feed_ctrl #(
        .N      (N),
        .DW     (DW),
        .AW     (AW),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int s;
        int set_id;
    } job_t;

    logic [31:0] mat_a [2][N][N];   // [set][i][k]
    logic [31:0] mat_b [2][N][N];   // [set][k][j]
    int          set_sel = 0;
    job_t        jobs[$];
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_err   = 0;
    int          next_ok = 0;
    int          t;
    int          k;
    bit          act;
    logic [31:0] e;

    function automatic logic [31:0] fp_int(input int n);
        case (n)
            0:  return 32'h0000_0000;
            1:  return 32'h3F80_0000;
            2:  return 32'h4000_0000;
            3:  return 32'h4040_0000;
            4:  return 32'h4080_0000;
            5:  return 32'h40A0_0000;
            6:  return 32'h40C0_0000;
            7:  return 32'h40E0_0000;
            8:  return 32'h4100_0000;
            9:  return 32'h4110_0000;
            10: return 32'h4120_0000;
            11: return 32'h4130_0000;
            12: return 32'h4140_0000;
            13: return 32'h4150_0000;
            14: return 32'h4160_0000;
            default: return 32'h4170_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Operand buffers: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.a_rd_en) begin
            for (int i = 0; i < N; i++) bus.a_rd_data[i] <= mat_a[set_sel][i][bus.a_rd_addr];
        end
        if (bus.b_rd_en) begin
            for (int j = 0; j < N; j++) bus.b_rd_data[j] <= mat_b[set_sel][bus.b_rd_addr][j];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare every output against the active job's timeline, then accept new jobs.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (jobs.size() > 0 && (cyc - jobs[0].s) > DONE_T) void'(jobs.pop_front());
            act = (jobs.size() > 0);
            t   = act ? (cyc - jobs[0].s) : -100;
            chk("busy",   64'(bus.busy),   64'(act && t >= 1 && t <= DONE_T));
            chk("done",   64'(bus.done),   64'(act && t == DONE_T));
            chk("pe_clr", 64'(bus.pe_clr), 64'(act && t == 1));
            chk("a_rd_en", 64'(bus.a_rd_en), 64'(act && t >= 2 && t <= N + 1));
            chk("b_rd_en", 64'(bus.b_rd_en), 64'(act && t >= 2 && t <= N + 1));
            chk("a_rd_addr", 64'(bus.a_rd_addr),
                64'((act && t >= 2) ? ((t - 2 < N - 1) ? t - 2 : N - 1) : 0));
            chk("b_rd_addr", 64'(bus.b_rd_addr),
                64'((act && t >= 2) ? ((t - 2 < N - 1) ? t - 2 : N - 1) : 0));
            for (int i = 0; i < N; i++) begin
                k = t - 4 - i;
                e = (act && k >= 0 && k < N) ? mat_a[jobs[0].set_id][i][k] : 32'h0;
                chk($sformatf("left%0d", i), 64'(bus.left_data[i]), 64'(e));
                e = (act && k >= 0 && k < N) ? mat_b[jobs[0].set_id][k][i] : 32'h0;
                chk($sformatf("top%0d", i), 64'(bus.top_data[i]), 64'(e));
            end
        end
        if (rst) begin
            jobs.delete();
            next_ok = cyc + 1;
        end else if (bus.start && cyc >= next_ok) begin
            jobs.push_back('{cyc, set_sel});
            next_ok = cyc + JOB_INT;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mat_a[0][i][j] = (i == j) ? 32'h3F80_0000 : 32'h0;
                mat_b[0][i][j] = 32'h3F00_0000;
                mat_a[1][i][j] = fp_int(i * 4 + j);
                mat_b[1][i][j] = 32'h4000_0000;
            end
        end

        // Reset for two cycles, then a quiet idle stretch.
        step(2);
        rst = 1'b0;
        step(20);

        // Single job: identity x 0.5.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(25);

        // START held high: jobs every JOB_INT cycles.
        bus.start = 1'b1;
        step(50);
        bus.start = 1'b0;
        step(25);

        // Reset in the middle of FEED, then a fresh job.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(25);

        // Skew integrity with distinct A values and B = 2.0.
        set_sel = 1;
        step(2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequences one N x N FP32 output-stationary matrix multiply on the P_Element systolic array.
- Reads operand columns of A and rows of B from two operand buffers.
- Skews them onto the array's left and top edges, row i and column j delayed by i and j cycles.
- Clears the PE accumulators, then waits out array propagation plus PE pipeline latency and pulses DONE.

Parameters:
- N, 4, array dimension (rows = columns = inner dimension K), 2..16
- DW, 32, element width (IEEE-754 single)
- AW, 2, operand buffer address width, equal to clog2(N)
- PE_LAT, 3, cycles from a PE sampling IN_TOP/IN_LEFT to its accumulator holding the sum

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin a multiply; sampled only in IDLE
- BUSY  out  1  high from CLEAR through DONE inclusive
- DONE  out  1  one-cycle pulse; all PE accumulators final
- PE_CLR  out  1  clears every PE accumulator (broadcast)
- A_RD_EN  out  1  read strobe to A buffer
- A_RD_ADDR  out  AW  k; A buffer returns column k of A
- A_RD_DATA  in  N*DW  lane i = A[i][k], valid the cycle after A_RD_EN
- B_RD_EN  out  1  read strobe to B buffer
- B_RD_ADDR  out  AW  k; B buffer returns row k of B
- B_RD_DATA  in  N*DW  lane j = B[k][j], valid the cycle after B_RD_EN
- LEFT_DATA  out  N*DW  lane i drives IN_LEFT of PE(i,0)
- TOP_DATA  out  N*DW  lane j drives IN_TOP of PE(0,j)

Behaviour:
- Reset values: BUSY=0, DONE=0, PE_CLR=0, both RD_EN=0, both RD_ADDR=0, LEFT_DATA=0, TOP_DATA=0, all skew registers=0, FSM=IDLE.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR when START=1. START is ignored in every other state; no queuing.
- CLEAR lasts 1 cycle: PE_CLR=1.
- FEED lasts N cycles, k=0..N-1: A_RD_EN=B_RD_EN=1, both addresses = k.
- DRAIN lasts 2N+PE_LAT cycles. No reads; edges are fed zeros.
- DONE lasts 1 cycle: DONE=1, BUSY=1. Next state is IDLE.
- Timing, with the START-sampling cycle as cycle 0:
  - CLEAR at cycle 1.
  - FEED at cycles 2..N+1.
  - Read data returns at cycles 3..N+2.
  - LEFT lane i shows A[i][k] during cycle 4+k+i; TOP lane j shows B[k][j] during cycle 4+k+j.
  - All lane outputs are registered.
  - DONE at cycle 3N+2+PE_LAT (N=4, PE_LAT=3 -> cycle 17).
- Lane gating:
  - Each lane carries a valid bit alongside its data through the skew chain.
  - A lane outputs 32'h00000000 (+0.0) whenever its valid bit is 0.
  - Consequently, outside its N-cycle window a lane outputs exactly zero; stale data never appears.
- Back-to-back jobs: START high during the DONE cycle is ignored. START in the following IDLE cycle is accepted, giving a minimum issue interval of 3N+4+PE_LAT cycles.
- RST at any time, including mid-FEED or mid-DRAIN:
  - Next cycle is IDLE with all reset values and all skew registers zeroed.
  - No DONE pulse is produced.
  - PE accumulators are not cleared by this block; the next CLEAR handles them.
- The read address counter saturates at N-1 and never wraps during FEED; it returns to 0 in IDLE.
- No arithmetic on data; values pass through bit-exact. Zero padding relies on 0*x=0, so inf/NaN operands are outside contract.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (ST_IDLE, ST_CLEAR, ST_FEED, ST_DRAIN, ST_DONE)
  - the FP32 zero constant
  - the drain-length expression 2N+PE_LAT
- One sub-module, skew_delay_line (parameters DEPTH, DW): DEPTH-stage register chain carrying data plus valid, with zero-gated output and synchronous clear.
- skew_delay_line is instantiated 2N times, with DEPTH = lane index + 1.

Test Plan:
- Reset then idle: RST high 2 cycles, START=0 for 20 cycles -> BUSY=0, DONE=0, all RD_EN=0, LEFT/TOP all 32'h0 throughout.
- Single job, N=4, PE_LAT=3, A=identity (1.0=32'h3F800000), B[k][j]=0.5 (32'h3F000000):
  - PE_CLR only at cycle 1; RD_EN cycles 2..5 with addresses 0,1,2,3.
  - LEFT lane 2 = 32'h3F800000 only at cycle 8 (k=2), zero otherwise.
  - TOP lane 3 = 32'h3F000000 at cycles 7..10.
  - DONE single pulse at cycle 17.
  - Array output PE(i,j) = 0.5.
- START held high continuously -> jobs start at cycles 0, 19, 38; DONE at 17, 36, 55; no START accepted while BUSY.
- RST asserted at cycle 4 (mid-FEED) -> cycle 5 in IDLE, LEFT/TOP zero, no DONE ever. A new START at cycle 10 gives DONE at cycle 27.
- Skew integrity with distinct values A[i][k] = i*4+k as float, B = 2.0 -> each lane shows its four values in order, with a 1-cycle per-lane stagger and zeros between jobs.
